// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU command controller.
package alu_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// Command, ALU and response signals of alu_ctrl.
// slave = the controller, master = the environment around it.
interface alu_ctrl_if #(
    parameter int N = alu_pkg::N_DEF
) ();
    import alu_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    alu_op_t         cmd_op;
    logic [N-1:0]    cmd_a;
    logic [N-1:0]    cmd_b;

    logic [N-1:0]    alu_in1;
    logic [N-1:0]    alu_in2;
    alu_op_t         alu_op;
    logic [N-1:0]    alu_out;
    logic            alu_z;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [N-1:0]    rsp_data;
    logic            rsp_zero;

    logic            busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_z, rsp_ready,
        output cmd_ready, alu_in1, alu_in2, alu_op, rsp_valid, rsp_data, rsp_zero, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_z, rsp_ready,
        input  cmd_ready, alu_in1, alu_in2, alu_op, rsp_valid, rsp_data, rsp_zero, busy
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra bit to tell full from empty.
module alu_cmd_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    // Pointer update; a write is refused when full even if a pop happens the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage write at the tail.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_ctrl.sv
// ALU command controller: queues commands, issues one at a time to an external
// ALU, waits ALU_LAT cycles, captures the result and holds it until accepted.
//
// state   | meaning
// IDLE    | nothing in flight; issue FIFO head when available
// WAIT    | command issued, counting down ALU latency
// RESP    | result captured, waiting for rsp_ready
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rstn,
    alu_ctrl_if.slave  bus
);
    localparam int W  = 2 + 2*N;
    localparam int CW = $clog2(ALU_LAT + 1);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic           pop;
    logic           issue;
    logic           capture;
    logic           full;
    logic           empty;
    logic [W-1:0]   head;

    logic [N-1:0]   in1_q;
    logic [N-1:0]   in2_q;
    alu_op_t        op_q;
    logic           rsp_valid_q;
    logic [N-1:0]   rsp_data_q;
    logic           rsp_zero_q;

    alu_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.cmd_valid && !full),
        .din   ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.cmd_ready = !full;
    assign bus.busy      = !empty || (state != ST_IDLE);
    assign bus.alu_in1   = in1_q;
    assign bus.alu_in2   = in2_q;
    assign bus.alu_op    = op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state and per-cycle strobes.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    issue     = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Issue registers, latency counter and result capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in1_q       <= '0;
            in2_q       <= '0;
            op_q        <= OP_ADD;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            if (issue) begin
                op_q  <= alu_op_t'(head[W-1 -: 2]);
                in1_q <= head[2*N-1 -: N];
                in2_q <= head[N-1:0];
                cnt   <= CW'(ALU_LAT);
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (capture) begin
                rsp_data_q  <= bus.alu_out;
                rsp_zero_q  <= bus.alu_z;
                rsp_valid_q <= 1'b1;
            end else if (state == ST_RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Testbench for alu_ctrl: directed scenarios followed by randomized traffic
// checked against an in-order queue of expected results.
module tb_alu_ctrl;
    import alu_pkg::*;

    localparam int N       = 8;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [N:0] exp_q [$];

    always #5 clk = ~clk;

    alu_ctrl_if #(.N(N)) bus ();

    alu_ctrl #(.N(N), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    function automatic logic [N-1:0] ref_alu(input alu_op_t op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a | b;
        endcase
    endfunction

    // External ALU: registered result, ALU_LAT cycles after the operands.
    logic [N-1:0] pipe_d [ALU_LAT];
    logic         pipe_z [ALU_LAT];
    always @(posedge clk) begin
        pipe_d[0] <= ref_alu(bus.alu_op, bus.alu_in1, bus.alu_in2);
        pipe_z[0] <= (ref_alu(bus.alu_op, bus.alu_in1, bus.alu_in2) == '0);
        for (int i = 1; i < ALU_LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_z[i] <= pipe_z[i-1];
        end
    end
    assign bus.alu_out = pipe_d[ALU_LAT-1];
    assign bus.alu_z   = pipe_z[ALU_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_cmd(input logic v, input alu_op_t op, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 20), 32'd1);
    endtask

    task automatic run_one(input alu_op_t op, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] exp_d, input logic exp_z, input string tag);
        @(negedge clk);
        drive_cmd(1'b1, op, a, b);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        drive_cmd(1'b0, OP_ADD, '0, '0);
        wait_rsp({tag, "_timeout"});
        check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_d));
        check({tag, "_zero"}, 32'(bus.rsp_zero), 32'(exp_z));
        @(negedge clk);
        check({tag, "_vclr"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [N-1:0] bb_d [5];
        logic         bb_z [5];
        logic [N-1:0] bb_a [5];
        logic [N-1:0] hold_d;
        logic         hold_z;
        logic [N-1:0] prev_d;
        logic         prev_z;
        logic         prev_hold;
        logic [N:0]   e;
        logic [N-1:0] r;
        int           n;

        drive_cmd(1'b0, OP_ADD, '0, '0);
        bus.rsp_ready = 1'b0;

        // Reset values.
        #2 rstn = 1'b0;
        #1;
        check("rst_in1",   32'(bus.alu_in1),   32'd0);
        check("rst_in2",   32'(bus.alu_in2),   32'd0);
        check("rst_op",    32'(bus.alu_op),    32'd0);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_data",  32'(bus.rsp_data),  32'd0);
        check("rst_zero",  32'(bus.rsp_zero),  32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);

        // ADD 5+10 with exact cycle timing.
        drive_cmd(1'b1, OP_ADD, 8'd5, 8'd10);
        bus.rsp_ready = 1'b1;
        @(negedge clk);                       // edge k accepted
        drive_cmd(1'b0, OP_ADD, '0, '0);
        check("add_k_in1", 32'(bus.alu_in1), 32'd0);
        @(negedge clk);                       // edge k+1 issue
        check("add_in1", 32'(bus.alu_in1), 32'd5);
        check("add_in2", 32'(bus.alu_in2), 32'd10);
        check("add_op",  32'(bus.alu_op),  32'd0);
        @(negedge clk);                       // edge k+2
        check("add_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);                       // edge k+3 capture
        check("add_valid", 32'(bus.rsp_valid), 32'd1);
        check("add_data",  32'(bus.rsp_data),  32'd15);
        check("add_zero",  32'(bus.rsp_zero),  32'd0);
        @(negedge clk);
        check("add_vclr",  32'(bus.rsp_valid), 32'd0);
        check("add_busy",  32'(bus.busy),      32'd0);
        check("add_hold",  32'(bus.alu_in1),   32'd5);

        run_one(OP_SUB, 8'd10, 8'd10, 8'h00, 1'b1, "sub_eq");
        run_one(OP_SUB, 8'd5,  8'd10, 8'hFB, 1'b0, "sub_neg");
        run_one(OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, "and");
        run_one(OP_OR,  8'h00, 8'h00, 8'h00, 1'b1, "or_zero");

        // Back-to-back fill with rsp_ready low; sixth command must stall.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            alu_op_t     op;
            logic [N-1:0] a;
            logic [N-1:0] b;
            @(negedge clk);
            op = alu_op_t'(i % 4);
            a  = 8'(i * 37 + 3);
            b  = 8'(i * 11 + 1);
            drive_cmd(1'b1, op, a, b);
            #1;
            check($sformatf("bb_ready%0d", i), 32'(bus.cmd_ready), 32'(i < 5));
            if (i < 5) begin
                bb_a[i] = a;
                bb_d[i] = ref_alu(op, a, b);
                bb_z[i] = (bb_d[i] == '0);
            end
        end
        @(negedge clk);
        check("bb_stall", 32'(bus.cmd_ready), 32'd0);
        drive_cmd(1'b0, OP_ADD, '0, '0);
        wait_rsp("bb_first_timeout");
        hold_d = bus.rsp_data;
        hold_z = bus.rsp_zero;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_data",  32'(bus.rsp_data),  32'(hold_d));
            check("hold_zero",  32'(bus.rsp_zero),  32'(hold_z));
            check("hold_noiss", 32'(bus.alu_in1),   32'(bb_a[0]));
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp("bb_drain_timeout");
            check($sformatf("bb_data%0d", i), 32'(bus.rsp_data), 32'(bb_d[i]));
            check($sformatf("bb_zero%0d", i), 32'(bus.rsp_zero), 32'(bb_z[i]));
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("bb_busy", 32'(bus.busy), 32'd0);

        // Reset during WAIT with two commands queued.
        drive_cmd(1'b1, OP_ADD, 8'd1, 8'd2);
        @(negedge clk);
        drive_cmd(1'b1, OP_SUB, 8'd9, 8'd4);
        @(negedge clk);
        drive_cmd(1'b1, OP_OR, 8'h11, 8'h22);
        @(negedge clk);
        drive_cmd(1'b0, OP_ADD, '0, '0);
        rstn = 1'b0;
        #1;
        check("mrst_in1",   32'(bus.alu_in1),   32'd0);
        check("mrst_in2",   32'(bus.alu_in2),   32'd0);
        check("mrst_op",    32'(bus.alu_op),    32'd0);
        check("mrst_valid", 32'(bus.rsp_valid), 32'd0);
        check("mrst_data",  32'(bus.rsp_data),  32'd0);
        check("mrst_busy",  32'(bus.busy),      32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("mrst_ready", 32'(bus.cmd_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.busy) n++;
        end
        check("mrst_quiet", 32'(n), 32'd0);

        // Randomized traffic against an in-order expectation queue.
        prev_hold = 1'b0;
        prev_d    = '0;
        prev_z    = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (prev_hold) begin
                check("rnd_hold_v", 32'(bus.rsp_valid), 32'd1);
                check("rnd_hold_d", 32'(bus.rsp_data),  32'(prev_d));
                check("rnd_hold_z", 32'(bus.rsp_zero),  32'(prev_z));
            end
            drive_cmd($urandom_range(0, 1) == 1, alu_op_t'($urandom_range(0, 3)),
                      N'($urandom_range(0, 15) == 0 ? 0 : $urandom),
                      N'($urandom_range(0, 15) == 0 ? 0 : $urandom));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.cmd_valid && bus.cmd_ready) begin
                r = ref_alu(bus.cmd_op, bus.cmd_a, bus.cmd_b);
                exp_q.push_back({r == '0, r});
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("rnd_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rnd_data", 32'(bus.rsp_data), 32'(e[N-1:0]));
                    check("rnd_zero", 32'(bus.rsp_zero), 32'(e[N]));
                end
            end
            prev_hold = bus.rsp_valid && !bus.rsp_ready;
            prev_d    = bus.rsp_data;
            prev_z    = bus.rsp_zero;
        end

        drive_cmd(1'b0, OP_ADD, '0, '0);
        bus.rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid) begin
                e = exp_q.pop_front();
                check("drain_data", 32'(bus.rsp_data), 32'(e[N-1:0]));
                check("drain_zero", 32'(bus.rsp_zero), 32'(e[N]));
            end
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        check("final_valid", 32'(bus.rsp_valid), 32'd0);
        check("final_busy",  32'(bus.busy),      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter N, default 8, operand/result width in bits.
REQ-002 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003 Parameter ALU_LAT, default 1, ALU clk-to-result latency in cycles (>=1).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rstn  in  1  reset, asynchronous and active-low.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command FIFO can accept.
REQ-008 cmd_op  in  2  ALU opcode (alu_op_t).
REQ-009 cmd_a  in  N  signed operand 1.
REQ-010 cmd_b  in  N  signed operand 2.
REQ-011 alu_in1  out  N  operand 1 to ALU, registered.
REQ-012 alu_in2  out  N  operand 2 to ALU, registered.
REQ-013 alu_op  out  2  opcode to ALU, registered.
REQ-014 alu_out  in  N  ALU result.
REQ-015 alu_z  in  1  ALU zero flag.
REQ-016 rsp_valid  out  1  result available.
REQ-017 rsp_ready  in  1  consumer accepts result.
REQ-018 rsp_data  out  N  captured result.
REQ-019 rsp_zero  out  1  captured zero flag.
REQ-020 busy  out  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-021 Command accepted on an edge where cmd_valid && cmd_ready; {op,a,b} written to FIFO tail.
REQ-022 cmd_ready = !full, independent of cmd_valid; no write when full, even if a pop occurs same cycle.
REQ-023 FSM states IDLE, WAIT, RESP; exactly one command in flight at a time.
REQ-024 IDLE: if FIFO non-empty, pop head, load alu_in1/alu_in2/alu_op, load counter with ALU_LAT, go WAIT; else stay.
REQ-025 WAIT: counter decrements each edge; on the edge where counter==0, capture alu_out->rsp_data, alu_z->rsp_zero, set rsp_valid, go RESP (capture edge = issue edge + ALU_LAT + 1).
REQ-026 RESP: hold rsp_valid, rsp_data, rsp_zero stable while rsp_ready low; on rsp_valid && rsp_ready, clear rsp_valid next edge and go IDLE.
REQ-027 With ALU_LAT=1, empty FIFO, idle FSM: command accepted edge k -> alu_* updated edge k+1 -> rsp_valid high after edge k+3.
REQ-028 alu_in1/alu_in2/alu_op hold last issued values outside issue edges.
REQ-029 Commands complete strictly in acceptance order; no command dropped or duplicated except on reset.
REQ-030 FIFO pointers wrap modulo DEPTH; full/empty via extra pointer MSB; simultaneous push and pop when neither full nor empty keeps count unchanged.
REQ-031 Result values pass through unmodified; no arithmetic performed in this block.

Reset
REQ-032 rstn low clears FSM to IDLE, FIFO pointers to 0, counter to 0, alu_in1/alu_in2/alu_op/rsp_data/rsp_zero/rsp_valid to 0, asynchronously.
REQ-033 Reset mid-operation discards all queued and in-flight commands; cmd_ready high after first edge with rstn high.

Structure
REQ-034 Package alu_pkg holds alu_op_t (ADD=0, SUB=1, AND=2, OR=3), N default, and FSM state typedef.
REQ-035 Sub-module alu_cmd_fifo (synchronous FIFO, width 2+2N, depth DEPTH) instantiated once; FSM and capture logic in alu_ctrl.

Verification
REQ-036 ADD a=5 b=10 into idle block, rsp_ready=1 -> alu_in1=5, alu_in2=10, alu_op=0 after edge k+1; rsp_data=15, rsp_zero=0 valid after edge k+3.
REQ-037 SUB a=10 b=10 -> rsp_data=0, rsp_zero=1; SUB a=5 b=10 -> rsp_data=8'hFB.
REQ-038 Back-to-back 5 commands with rsp_ready=0 -> first issued, next 4 fill FIFO, cmd_ready low, 6th stalled; releasing rsp_ready drains all in order.
REQ-039 rsp_ready low 3 cycles in RESP -> rsp_data/rsp_zero stable, no new issue until handshake.
REQ-040 rstn asserted during WAIT with 2 queued commands -> all outputs 0 immediately, busy=0, no response ever emitted for discarded commands.
